// File: rtl/branch_predictor_bht.sv
// Branch history/target table: direct-mapped, tagged, saturating counters.
// Ports: CLK/RST; fetch lookup PCF -> pred_taken/pred_target;
//        decode update upd_* -> mispredict/redirect_pc; stat_* counters.
module branch_predictor_bht #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PC_W-1:0]   PCF,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [PC_W-1:0]   upd_pcp1,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_miss
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag [ENTRIES];
    logic [CNT_W-1:0]   r_cnt [ENTRIES];
    logic [PC_W-1:0]    r_tgt [ENTRIES];
    logic [STAT_W-1:0]  r_br;
    logic [STAT_W-1:0]  r_miss;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_unused;

    // Fetch lookup reads the table as it stands; no bypass from the update.
    assign w_f_idx = PCF[IDX_W-1:0];
    assign w_f_tag = PCF[IDX_W+TAG_W-1:IDX_W];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign pred_taken  = w_f_hit && r_cnt[w_f_idx][CNT_W-1];
    assign pred_target = pred_taken ? r_tgt[w_f_idx] : PCF + PC_W'(1);

    assign w_u_idx = upd_pc[IDX_W-1:0];
    assign w_u_tag = upd_pc[IDX_W+TAG_W-1:IDX_W];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // Wrong direction, or right direction but the wrong target.
    assign mispredict = upd_valid &&
                        ((upd_pred != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pcp1;

    assign stat_branches = r_br;
    assign stat_miss     = r_miss;

    // Upper PC bits beyond tag+index take no part in the update path.
    assign w_unused = &{1'b0, upd_pc};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i] <= '0;
                r_cnt[i] <= CNT_WNT;
                r_tgt[i] <= '0;
            end
            r_br   <= '0;
            r_miss <= '0;
        end else if (upd_valid) begin
            if (r_br != '1)
                r_br <= r_br + STAT_ONE;
            if (mispredict && (r_miss != '1))
                r_miss <= r_miss + STAT_ONE;
            if (w_u_hit) begin
                if (upd_taken) begin
                    if (r_cnt[w_u_idx] != '1)
                        r_cnt[w_u_idx] <= r_cnt[w_u_idx] + CNT_ONE;
                    r_tgt[w_u_idx] <= upd_target;
                end else if (r_cnt[w_u_idx] != '0) begin
                    r_cnt[w_u_idx] <= r_cnt[w_u_idx] - CNT_ONE;
                end
            end else if (upd_taken) begin
                // Allocate weakly taken; a not-taken miss leaves the entry alone.
                r_valid[w_u_idx] <= 1'b1;
                r_tag[w_u_idx]   <= w_u_tag;
                r_cnt[w_u_idx]   <= CNT_WT;
                r_tgt[w_u_idx]   <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed vector bench for branch_predictor_bht (STAT_W=4 for saturation).
// Table-driven per-cycle vectors plus hand sequences for saturation/reset.
module tb_branch_predictor_bht;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] PCF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_pcp1;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_miss;

    int checks = 0;
    int errors = 0;

    branch_predictor_bht #(
        .PC_W(32), .IDX_W(4), .TAG_W(8), .CNT_W(2), .STAT_W(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PCF(PCF),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .upd_valid(upd_valid),
        .upd_pc(upd_pc),
        .upd_pcp1(upd_pcp1),
        .upd_taken(upd_taken),
        .upd_target(upd_target),
        .upd_pred(upd_pred),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .stat_branches(stat_branches),
        .stat_miss(stat_miss)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pcf;
        logic        uv;
        logic [31:0] upc;
        logic        tk;
        logic [31:0] tgt;
        logic        pr;
        logic [31:0] ptg;
        logic        ept;
        logic [31:0] eptg;
        logic        emis;
        logic [31:0] erd;
        int          ebr;
        int          emiss;
    } vec_t;

    vec_t v[23];

    function automatic vec_t mk(
        logic [31:0] pcf, logic uv, logic [31:0] upc, logic tk,
        logic [31:0] tgt, logic pr, logic [31:0] ptg,
        logic ept, logic [31:0] eptg, logic emis, logic [31:0] erd,
        int ebr, int emiss);
        vec_t r;
        r.pcf = pcf; r.uv = uv; r.upc = upc; r.tk = tk;
        r.tgt = tgt; r.pr = pr; r.ptg = ptg;
        r.ept = ept; r.eptg = eptg; r.emis = emis; r.erd = erd;
        r.ebr = ebr; r.emiss = emiss;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic [31:0] pc,
                         input logic tk, input logic [31:0] tgt,
                         input logic pr, input logic [31:0] ptg);
        upd_valid = uv;
        upd_pc = pc;
        upd_pcp1 = pc + 32'd1;
        upd_taken = tk;
        upd_target = tgt;
        upd_pred = pr;
        upd_pred_target = ptg;
    endtask

    task automatic look(input string nm, input logic [31:0] pc,
                        input logic ept, input logic [31:0] eptg);
        PCF = pc;
        #1;
        chk({nm, " pt"}, 32'(pred_taken), 32'(ept));
        chk({nm, " ptgt"}, pred_target, eptg);
    endtask

    initial begin
        v[0]  = mk(32'h10, 1, 32'h10, 1, 32'h40, 0, 32'h11, 0, 32'h11, 1, 32'h40, 0, 0);
        v[1]  = mk(32'h10, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 1, 1);
        v[2]  = mk(32'h10, 1, 32'h10, 0, 32'h40, 1, 32'h40, 1, 32'h40, 1, 32'h11, 1, 1);
        v[3]  = mk(32'h10, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0, 0, 2, 2);
        v[4]  = mk(32'h10, 1, 32'h10, 1, 32'h40, 0, 32'h11, 0, 32'h11, 1, 32'h40, 2, 2);
        v[5]  = mk(32'h10, 1, 32'h10, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 0, 3, 3);
        v[6]  = mk(32'h10, 1, 32'h10, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 0, 4, 3);
        v[7]  = mk(32'h10, 1, 32'h10, 1, 32'h40, 1, 32'h40, 1, 32'h40, 0, 0, 5, 3);
        v[8]  = mk(32'h10, 1, 32'h10, 0, 32'h40, 1, 32'h40, 1, 32'h40, 1, 32'h11, 6, 3);
        v[9]  = mk(32'h10, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 7, 4);
        v[10] = mk(32'h10, 1, 32'h10, 0, 32'h40, 0, 32'h11, 1, 32'h40, 0, 0, 7, 4);
        v[11] = mk(32'h10, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0, 0, 8, 4);
        v[12] = mk(32'h110, 0, 0, 0, 0, 0, 0, 0, 32'h111, 0, 0, 8, 4);
        v[13] = mk(32'h110, 1, 32'h110, 1, 32'h80, 0, 32'h111, 0, 32'h111, 1, 32'h80, 8, 4);
        v[14] = mk(32'h10, 0, 0, 0, 0, 0, 0, 0, 32'h11, 0, 0, 9, 5);
        v[15] = mk(32'h110, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0, 0, 9, 5);
        v[16] = mk(32'h110, 1, 32'h110, 1, 32'h84, 1, 32'h80, 1, 32'h80, 1, 32'h84, 9, 5);
        v[17] = mk(32'h110, 0, 0, 0, 0, 0, 0, 1, 32'h84, 0, 0, 10, 6);
        v[18] = mk(32'h20, 1, 32'h20, 1, 32'h44, 1, 32'h40, 0, 32'h21, 1, 32'h44, 10, 6);
        v[19] = mk(32'h20, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0, 11, 7);
        v[20] = mk(32'h33, 1, 32'h33, 0, 0, 0, 32'h34, 0, 32'h34, 0, 0, 11, 7);
        v[21] = mk(32'h33, 0, 0, 0, 0, 0, 0, 0, 32'h34, 0, 0, 12, 7);
        v[22] = mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 12, 7);

        RST = 1'b0;
        PCF = 32'h20;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        #1;
        chk("rst pt", 32'(pred_taken), 32'd0);
        chk("rst ptgt", pred_target, 32'h21);
        chk("rst br", 32'(stat_branches), 32'd0);
        chk("rst miss", 32'(stat_miss), 32'd0);
        RST = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge CLK);
            PCF = v[i].pcf;
            drive(v[i].uv, v[i].upc, v[i].tk, v[i].tgt, v[i].pr, v[i].ptg);
            #1;
            chk($sformatf("v%0d pt", i), 32'(pred_taken), 32'(v[i].ept));
            chk($sformatf("v%0d ptgt", i), pred_target, v[i].eptg);
            chk($sformatf("v%0d mis", i), 32'(mispredict), 32'(v[i].emis));
            if (v[i].emis)
                chk($sformatf("v%0d rd", i), redirect_pc, v[i].erd);
            chk($sformatf("v%0d br", i), 32'(stat_branches), 32'(v[i].ebr));
            chk($sformatf("v%0d miss", i), 32'(stat_miss), 32'(v[i].emiss));
        end

        // Twenty mispredicting updates: both stats pin at 15.
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            drive(1, 32'h50, 1, 32'h60, 0, 32'h51);
            #1;
            chk($sformatf("sat%0d mis", k), 32'(mispredict), 32'd1);
        end
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("sat br", 32'(stat_branches), 32'd15);
        chk("sat miss", 32'(stat_miss), 32'd15);
        look("sat lk", 32'h50, 1, 32'h60);

        // Mid-cycle reset with an update pending.
        drive(1, 32'h50, 1, 32'h60, 0, 32'h51);
        RST = 1'b0;
        #1;
        chk("mrst br", 32'(stat_branches), 32'd0);
        chk("mrst miss", 32'(stat_miss), 32'd0);
        chk("mrst mis", 32'(mispredict), 32'd1);
        look("mrst lk50", 32'h50, 0, 32'h51);
        @(posedge CLK);
        #1;
        chk("mrst br2", 32'(stat_branches), 32'd0);
        look("mrst lk50b", 32'h50, 0, 32'h51);
        look("mrst lk110", 32'h110, 0, 32'h111);
        look("mrst lk20", 32'h20, 0, 32'h21);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        #1;
        look("post lk50", 32'h50, 0, 32'h51);
        @(negedge CLK);
        drive(1, 32'h50, 1, 32'h60, 0, 32'h51);
        #1;
        chk("post mis", 32'(mispredict), 32'd1);
        chk("post rd", redirect_pc, 32'h60);
        chk("post pt", 32'(pred_taken), 32'd0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post br", 32'(stat_branches), 32'd1);
        chk("post miss", 32'(stat_miss), 32'd1);
        look("post lk", 32'h50, 1, 32'h60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history/target table for the five-stage pipelined processor. Fetch looks up PCF and gets a taken/not-taken prediction plus next-fetch address in the same cycle. Decode, where branches resolve, reports each outcome. The block trains its saturating counters, flags mispredictions and supplies the redirect PC. It replaces the current static predict-not-taken scheme, which flushes on every taken branch.

## Interface
- PC_W, 32, PC/address width (word-addressed; sequential PC is PC+1)
- IDX_W, 4, index bits; table holds 2^IDX_W entries
- TAG_W, 8, tag bits; PC_W >= IDX_W+TAG_W required
- CNT_W, 2, saturating counter width; CNT_W >= 2 required
- STAT_W, 16, statistics counter width

- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- PCF  in  PC_W  fetch-stage PC
- pred_taken  out  1  prediction for PCF
- pred_target  out  PC_W  next fetch address
- upd_valid  in  1  a branch resolved in decode this cycle
- upd_pc  in  PC_W  PC of the resolving branch
- upd_pcp1  in  PC_W  upd_pc+1 (fall-through)
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual branch target
- upd_pred  in  1  pred_taken carried down from fetch
- upd_pred_target  in  PC_W  pred_target carried down from fetch
- mispredict  out  1  flush request for fetch/decode
- redirect_pc  out  PC_W  correct next PC when mispredict=1
- stat_branches  out  STAT_W  resolved-branch count
- stat_miss  out  STAT_W  mispredict count

## Operation
- Entry fields: valid, tag, counter[CNT_W], target[PC_W].
- Addressing: idx = PC[IDX_W-1:0]; tag = PC[IDX_W+TAG_W-1:IDX_W].
- Hit: entry valid and tag equal.
- Lookup (combinational): pred_taken = hit && counter MSB. pred_target = stored target if pred_taken, else PCF+1 (mod 2^PC_W).
- Update, on each edge with upd_valid=1, indexed by upd_pc:
  - Hit: counter saturating +1 if taken, −1 if not taken. Target overwritten with upd_target when taken.
  - Miss, taken: allocate. valid=1, new tag, counter = 2^(CNT_W-1) (weakly taken), target = upd_target.
  - Miss, not taken: no change.
- mispredict (combinational) = upd_valid && ((upd_pred != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- redirect_pc = upd_taken ? upd_target : upd_pcp1. It is valid only when mispredict=1.
- Statistics: stat_branches increments on every upd_valid edge. stat_miss increments when mispredict=1. Both saturate at all-ones and never wrap.
- upd_valid=0: no state change. Outputs still track PCF.

## Timing
- Lookup latency 0 cycles (combinational from PCF and table state). Update visible to lookups from the cycle after the edge.
- Simultaneous lookup and update to the same index: lookup returns pre-update contents. No write-through bypass.
- mispredict/redirect_pc are combinational in the resolve cycle so decode can flush in that cycle.
- Reset (RST=0, any time, including mid-update) immediately clears:
  - all valid bits to 0
  - counters to 2^(CNT_W-1)-1 (weakly not taken)
  - targets and both stat counters to 0
- While RST=0: pred_taken=0, pred_target=PCF+1. mispredict follows its combinational equation.
- No updates occur while RST=0. The first update is on the first rising edge after RST rises.

## Test plan
- Reset: RST=0, then PCF=0x20 -> pred_taken=0, pred_target=0x21, stat_branches=stat_miss=0.
- Allocate: upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40, upd_pred=0 -> mispredict=1, redirect_pc=0x40. Next cycle PCF=0x10 -> pred_taken=1, pred_target=0x40; counter=2; stat_miss=1.
- Hysteresis (CNT_W=2): from counter 2, one not-taken update -> counter 1, pred_taken=0. Three taken updates -> counter 3, a fourth stays 3. Not-taken with upd_pred=0, upd_pcp1=0x11 -> mispredict=0.
- Alias (IDX_W=4, TAG_W=8): entry for 0x10 present; PCF=0x110 -> miss, pred_taken=0. Taken update for 0x110 target 0x80 replaces the entry; PCF=0x10 then misses.
- Same-cycle update and lookup of 0x10 (allocating taken): pred_taken=0 that cycle, 1 the next. Wrong-target case: upd_pred=1, upd_pred_target=0x40, upd_target=0x44 -> mispredict=1, redirect_pc=0x44.
- Saturation (STAT_W=4): 20 consecutive mispredicting updates -> stat_miss=15, stat_branches=15. RST pulse mid-run -> both 0 and all lookups miss.
